// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester ids,
// cache-line geometry and the line-alignment helper.
package mem_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam logic [63:0] LINE_MASK  = ~(64'(LINE_BYTES) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  // Drop the byte-within-line bits of an address.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser.
// Ports: req[0]=fetch, req[1]=data; last = requester granted most recently;
//        grant = one-hot choice (all zero when nothing is requested).
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic [1:0] grant
);

  // With both requesting, the one not served last time wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (last == REQ_DC) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one line-wide memory port between an instruction-fetch
// requester and a data requester, one transaction outstanding at a time.
// Ports:
//   ic_enable/iaddr/ic_flush -> fetch request, idata/ic_done fetch response
//   dc_enable/daddr/dc_we/dc_wdata -> data request, dc_rdata/dc_done response
//   mem_req/mem_addr/mem_we/mem_wdata -> memory request (held until mem_ack)
//   mem_ack/mem_rdata/mem_done <- memory handshake and completion
//   err -> sticky protocol / timeout error
module mem_arb
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ic_enable,
  input  logic [63:0]  iaddr,
  input  logic         ic_flush,
  output logic [511:0] idata,
  output logic         ic_done,
  input  logic         dc_enable,
  input  logic [63:0]  daddr,
  input  logic         dc_we,
  input  logic [511:0] dc_wdata,
  output logic [511:0] dc_rdata,
  output logic         dc_done,
  output logic         mem_req,
  output logic [63:0]  mem_addr,
  output logic         mem_we,
  output logic [511:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [511:0] mem_rdata,
  input  logic         mem_done,
  output logic         err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e         state_r, state_n;
  req_id_e        cur_id_r, last_grant_r;
  logic           if_pend_r, dc_pend_r, dc_we_r, squash_r;
  logic [63:0]    if_addr_r, dc_addr_r;
  logic [511:0]   dc_wdata_r;
  logic [CNT_W-1:0] cnt_r;
  logic           mem_req_r, mem_we_r, ic_done_r, dc_done_r, err_r;
  logic [63:0]    mem_addr_r;
  logic [511:0]   mem_wdata_r, idata_r, dc_rdata_r;

  logic [1:0]     req_s, grant_s;
  logic           busy_s, dc_bad_s, dc_take_s, start_s;
  logic [63:0]    iss_addr_s;
  logic           iss_we_s;
  logic [511:0]   iss_wdata_s;

  assign busy_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

  // Effective requests include same-cycle enables so an idle arbiter issues
  // on the very next cycle; a flush only cancels an already-latched fetch.
  always_comb begin
    req_s[0]  = ic_enable | (if_pend_r & ~ic_flush);
    req_s[1]  = dc_enable | dc_pend_r;
    dc_bad_s  = dc_enable & (dc_pend_r | (busy_s & (cur_id_r == REQ_DC)));
    dc_take_s = dc_enable & ~dc_bad_s;
  end

  rr_arb2 u_rr (
    .req   (req_s),
    .last  (last_grant_r),
    .grant (grant_s)
  );

  // Next-state logic and selection of the request to launch.
  always_comb begin
    state_n     = state_r;
    start_s     = 1'b0;
    iss_addr_s  = 64'd0;
    iss_we_s    = 1'b0;
    iss_wdata_s = 512'd0;
    if (grant_s[1]) begin
      iss_addr_s  = dc_pend_r ? dc_addr_r  : daddr;
      iss_we_s    = dc_pend_r ? dc_we_r    : dc_we;
      iss_wdata_s = dc_pend_r ? dc_wdata_r : dc_wdata;
    end else begin
      iss_addr_s  = ic_enable ? iaddr : if_addr_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (|grant_s) begin
          state_n = ST_ISSUE;
          start_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          state_n = ST_RESP;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, request slots, memory-side outputs, responses and error tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cur_id_r     <= REQ_IF;
      last_grant_r <= REQ_IF;
      if_pend_r    <= 1'b0;
      if_addr_r    <= 64'd0;
      dc_pend_r    <= 1'b0;
      dc_addr_r    <= 64'd0;
      dc_we_r      <= 1'b0;
      dc_wdata_r   <= 512'd0;
      squash_r     <= 1'b0;
      cnt_r        <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= 512'd0;
      ic_done_r    <= 1'b0;
      dc_done_r    <= 1'b0;
      idata_r      <= 512'd0;
      dc_rdata_r   <= 512'd0;
      err_r        <= 1'b0;
    end else begin
      state_r   <= state_n;
      ic_done_r <= 1'b0;
      dc_done_r <= 1'b0;

      // Latest fetch address wins; an enable alongside a flush is kept.
      if (ic_enable) begin
        if_pend_r <= 1'b1;
        if_addr_r <= iaddr;
      end else if (ic_flush) begin
        if_pend_r <= 1'b0;
      end
      if (dc_take_s) begin
        dc_pend_r  <= 1'b1;
        dc_addr_r  <= daddr;
        dc_we_r    <= dc_we;
        dc_wdata_r <= dc_wdata;
      end
      if (dc_bad_s) begin
        err_r <= 1'b1;
      end

      if (ic_flush && busy_s && (cur_id_r == REQ_IF)) begin
        squash_r <= 1'b1;
      end

      // Launch: the granted slot empties here and may refill next cycle.
      if (start_s) begin
        if (grant_s[1]) begin
          dc_pend_r    <= 1'b0;
          cur_id_r     <= REQ_DC;
          last_grant_r <= REQ_DC;
        end else begin
          if_pend_r    <= 1'b0;
          cur_id_r     <= REQ_IF;
          last_grant_r <= REQ_IF;
        end
        squash_r    <= 1'b0;
        cnt_r       <= '0;
        mem_req_r   <= 1'b1;
        mem_addr_r  <= line_align(iss_addr_s);
        mem_we_r    <= iss_we_s;
        mem_wdata_r <= iss_wdata_s;
      end

      if (state_r == ST_ISSUE && mem_ack) begin
        mem_req_r <= 1'b0;
      end

      // Timeout only flags; the transaction keeps waiting for memory.
      if (busy_s) begin
        if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end

      if (state_r == ST_WAIT && mem_done) begin
        if (cur_id_r == REQ_DC) begin
          dc_done_r  <= 1'b1;
          dc_rdata_r <= mem_rdata;
        end else begin
          ic_done_r  <= ~squash_r;
          idata_r    <= mem_rdata;
        end
      end

      if ((mem_ack && state_r != ST_ISSUE) || (mem_done && state_r != ST_WAIT)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign ic_done   = ic_done_r;
  assign dc_done   = dc_done_r;
  assign idata     = idata_r;
  assign dc_rdata  = dc_rdata_r;
  assign err       = err_r;

endmodule
